// File: rtl/eth_pkg.sv
// Shared Ethernet constants, transmit FSM state type and a byte-wise CRC32 step.
// Used by eth_tx_framer and eth_crc32 (and later by the RX checker).
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hC704DD7B;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_DROP,
    ST_IFG
  } tx_state_e;

  // One byte of reflected CRC32: xor the byte into the low bits, then shift
  // out eight bits LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-wise IEEE 802.3 CRC32 accumulator (reflected), one byte per clock.
// Ports:
//   clk, rst  : clock, async active-high reset (crc -> CRC32_INIT)
//   init      : reload CRC32_INIT (has priority over en)
//   en, data  : fold data[7:0] into the running CRC
//   crc       : raw, uncomplemented CRC register
module eth_crc32
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] r_crc;
  logic [31:0] w_crc_nxt;

  always_comb begin
    w_crc_nxt = crc32_byte(r_crc, data);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_crc <= CRC32_INIT;
    end else if (init) begin
      r_crc <= CRC32_INIT;
    end else if (en) begin
      r_crc <= w_crc_nxt;
    end
  end

  assign crc = r_crc;

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet transmit framer: preamble + SFD, upstream bytes, zero pad to the
// minimum length, CRC32 FCS (LSB byte first), then the inter-frame gap.
// Ports:
//   clk, rst                            : byte clock, async active-high reset
//   s_tvalid/s_tready/s_tdata/s_tlast   : upstream byte stream (dest MAC first)
//   tvalid, tdata                       : byte stream to eth_tx, one byte per clk
//   underrun                            : one-cycle pulse when s_tvalid drops mid-frame
module eth_tx_framer
  import eth_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned MIN_FRAME    = 60,
  parameter int unsigned IFG_BYTES    = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_tvalid,
  output logic       s_tready,
  input  logic [7:0] s_tdata,
  input  logic       s_tlast,
  output logic       tvalid,
  output logic [7:0] tdata,
  output logic       underrun
);

  localparam logic [10:0] BYTE_CNT_MAX = '1;
  localparam logic [11:0] MIN_W        = 12'(MIN_FRAME);
  localparam logic [3:0]  PRE_LAST     = 4'(PREAMBLE_LEN - 1);
  localparam logic [3:0]  IFG_LAST     = 4'(IFG_BYTES - 1);

  tx_state_e   r_state, w_state_nxt;
  logic [10:0] r_byte_cnt, w_byte_cnt_nxt, w_byte_cnt_sat;
  logic [11:0] w_byte_cnt_inc;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_tvalid, w_tvalid_nxt;
  logic [7:0]  r_tdata, w_tdata_nxt;
  logic        r_tready;
  logic        r_underrun, w_underrun_nxt;
  logic        w_crc_init, w_crc_en;
  logic [7:0]  w_crc_data;
  logic [31:0] w_crc, w_fcs;

  eth_crc32 u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (w_crc_init),
    .en   (w_crc_en),
    .data (w_crc_data),
    .crc  (w_crc)
  );

  assign w_fcs          = ~w_crc;
  assign w_byte_cnt_inc = {1'b0, r_byte_cnt} + 12'd1;
  assign w_byte_cnt_sat = (r_byte_cnt == BYTE_CNT_MAX) ? r_byte_cnt : r_byte_cnt + 11'd1;

  // The state names what is loaded into the output registers at the end of
  // the cycle, so each emitted byte appears one clock after its state.
  // IDLE therefore loads the first preamble byte itself and PRE the rest.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_byte_cnt_nxt = r_byte_cnt;
    w_tvalid_nxt   = 1'b0;
    w_tdata_nxt    = '0;
    w_underrun_nxt = 1'b0;
    w_crc_init     = 1'b0;
    w_crc_en       = 1'b0;
    w_crc_data     = s_tdata;

    unique case (r_state)
      ST_IDLE: begin
        if (s_tvalid) begin
          w_tvalid_nxt = 1'b1;
          w_tdata_nxt  = ETH_PREAMBLE;
          w_cnt_nxt    = 4'd1;
          w_state_nxt  = (PREAMBLE_LEN > 1) ? ST_PRE : ST_SFD;
        end
      end
      ST_PRE: begin
        w_tvalid_nxt = 1'b1;
        w_tdata_nxt  = ETH_PREAMBLE;
        w_cnt_nxt    = r_cnt + 4'd1;
        if (r_cnt == PRE_LAST) begin
          w_state_nxt = ST_SFD;
        end
      end
      ST_SFD: begin
        w_tvalid_nxt   = 1'b1;
        w_tdata_nxt    = ETH_SFD;
        w_crc_init     = 1'b1;
        w_byte_cnt_nxt = '0;
        w_state_nxt    = ST_DATA;
      end
      ST_DATA: begin
        if (s_tvalid) begin
          w_tvalid_nxt   = 1'b1;
          w_tdata_nxt    = s_tdata;
          w_crc_en       = 1'b1;
          w_byte_cnt_nxt = w_byte_cnt_sat;
          if (s_tlast) begin
            w_cnt_nxt = '0;
            if (w_byte_cnt_inc < MIN_W) begin
              w_state_nxt = ST_PAD;
            end else begin
              w_state_nxt = ST_FCS;
            end
          end
        end else begin
          w_underrun_nxt = 1'b1;
          w_state_nxt    = ST_DROP;
        end
      end
      ST_PAD: begin
        w_tvalid_nxt   = 1'b1;
        w_crc_en       = 1'b1;
        w_crc_data     = '0;
        w_byte_cnt_nxt = w_byte_cnt_sat;
        if (w_byte_cnt_inc == MIN_W) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_FCS;
        end
      end
      ST_FCS: begin
        w_tvalid_nxt = 1'b1;
        unique case (r_cnt[1:0])
          2'd0: w_tdata_nxt = w_fcs[7:0];
          2'd1: w_tdata_nxt = w_fcs[15:8];
          2'd2: w_tdata_nxt = w_fcs[23:16];
          2'd3: w_tdata_nxt = w_fcs[31:24];
        endcase
        w_cnt_nxt = r_cnt + 4'd1;
        if (r_cnt[1:0] == 2'd3) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IFG;
        end
      end
      ST_DROP: begin
        if (s_tvalid && s_tlast) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IFG;
        end
      end
      ST_IFG: begin
        w_cnt_nxt = r_cnt + 4'd1;
        if (r_cnt == IFG_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_byte_cnt <= '0;
      r_tvalid   <= 1'b0;
      r_tdata    <= '0;
      r_tready   <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_tvalid   <= w_tvalid_nxt;
      r_tdata    <= w_tdata_nxt;
      r_tready   <= (w_state_nxt == ST_DATA) || (w_state_nxt == ST_DROP);
      r_underrun <= w_underrun_nxt;
    end
  end

  assign s_tready = r_tready;
  assign tvalid   = r_tvalid;
  assign tdata    = r_tdata;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Self-checking bench for eth_tx_framer (and the eth_crc32 unit).
module tb_eth_tx_framer;
  import eth_pkg::*;

  localparam int PRE_N = 7;
  localparam int MINF  = 60;
  localparam int IFG_N = 12;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       s_tvalid = 1'b0;
  logic       s_tready;
  logic [7:0] s_tdata  = '0;
  logic       s_tlast  = 1'b0;
  logic       tvalid;
  logic [7:0] tdata;
  logic       underrun;

  logic        c_init = 1'b0;
  logic        c_en   = 1'b0;
  logic [7:0]  c_data = '0;
  logic [31:0] c_crc;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] frm[$];
  logic [7:0] out_q[$];
  int         gap_q[$];
  int         tready_cnt  = 0;
  int         urun_cnt    = 0;
  int         urun_tv_bad = 0;
  int         zero_run    = 0;
  bit         seen_tv     = 1'b0;

  eth_tx_framer #(
    .PREAMBLE_LEN (PRE_N),
    .MIN_FRAME    (MINF),
    .IFG_BYTES    (IFG_N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .s_tlast  (s_tlast),
    .tvalid   (tvalid),
    .tdata    (tdata),
    .underrun (underrun)
  );

  eth_crc32 u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (c_init),
    .en   (c_en),
    .data (c_data),
    .crc  (c_crc)
  );

  always #5 clk = ~clk;

  // Output monitor: record every valid byte, idle-run lengths between frames,
  // s_tready-high cycles and underrun pulses.
  always @(negedge clk) begin
    if (tvalid) begin
      if (seen_tv && zero_run > 0) gap_q.push_back(zero_run);
      seen_tv  = 1'b1;
      zero_run = 0;
      out_q.push_back(tdata);
    end else begin
      zero_run++;
    end
    if (s_tready) tready_cnt++;
    if (underrun) begin
      urun_cnt++;
      if (tvalid) urun_tv_bad++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Textbook bit-serial reflected CRC32, raw register (no final inversion).
  function automatic logic [31:0] crc_raw(input logic [7:0] q[$]);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (q[k]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ q[k][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return c;
  endfunction

  function automatic void build_exp(input logic [7:0] d[$], output logic [7:0] e[$]);
    logic [7:0]  body[$];
    logic [31:0] fcs;
    body = d;
    while (body.size() < MINF) body.push_back(8'h00);
    fcs = ~crc_raw(body);
    e = {};
    repeat (PRE_N) e.push_back(8'h55);
    e.push_back(8'hD5);
    foreach (body[k]) e.push_back(body[k]);
    for (int k = 0; k < 4; k++) e.push_back(fcs[8*k +: 8]);
  endfunction

  task automatic fill_rand(input int n);
    frm.delete();
    repeat (n) frm.push_back(8'($urandom));
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    repeat (n) begin
      s_tlast = 1'($urandom);
      s_tdata = 8'($urandom);
      @(posedge clk); #1;
    end
    s_tlast = 1'b0;
  endtask

  // Drives frm; drops s_tvalid for one cycle at gap_at, asserts rst at rst_at.
  // Leaves s_tvalid high after the last byte so frames can be chained.
  task automatic send_frame(input int gap_at, input int rst_at);
    int i      = 0;
    int budget = 0;
    bit hs;
    bit gapped = 1'b0;
    while (i < frm.size()) begin
      if (i == rst_at) begin
        chk("pre_rst_tvalid", 32'(tvalid), 32'd1);
        chk("pre_rst_tready", 32'(s_tready), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_tvalid", 32'(tvalid), 32'd0);
        chk("rst_tready", 32'(s_tready), 32'd0);
        chk("rst_tdata", 32'(tdata), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        return;
      end
      s_tvalid = 1'b1;
      if (i == gap_at && !gapped) begin
        s_tvalid = 1'b0;
        gapped   = 1'b1;
      end
      s_tdata = frm[i];
      s_tlast = (i == frm.size() - 1);
      @(negedge clk);
      hs = s_tvalid && s_tready;
      @(posedge clk); #1;
      if (hs) i++;
      budget++;
      if (budget > 4000) begin
        chk("send_timeout", 32'(i), 32'(frm.size()));
        return;
      end
    end
  endtask

  task automatic wait_out(input int target);
    int cyc = 0;
    while (out_q.size() < target && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
    end
    repeat (IFG_N + 4) @(posedge clk);
    #1;
  endtask

  task automatic cmp_stream(input string tag, input int base, input logic [7:0] e[$]);
    int nbad = 0;
    chk({tag, "_len"}, 32'(out_q.size() - base), 32'(e.size()));
    for (int k = 0; k < e.size() && base + k < out_q.size(); k++)
      if (out_q[base + k] !== e[k]) nbad++;
    chk({tag, "_bytes_bad"}, 32'(nbad), 32'd0);
  endtask

  // Residue of the observed data/pad/FCS bytes; the reflected register holds
  // the bit-reverse of the standard residue constant.
  task automatic chk_residue(input string tag, input int first, input int last);
    logic [7:0]  q[$];
    logic [31:0] raw, rev;
    for (int k = first; k <= last && k < out_q.size(); k++) q.push_back(out_q[k]);
    raw = crc_raw(q);
    rev = {<<{raw}};
    chk({tag, "_residue"}, rev, CRC32_RESIDUE);
  endtask

  task automatic run_frame(input string tag, input bit lat);
    logic [7:0] e[$];
    int base, tr0, ur0;
    build_exp(frm, e);
    base = out_q.size();
    tr0  = tready_cnt;
    ur0  = urun_cnt;
    if (lat) begin
      s_tvalid = 1'b1;
      s_tdata  = frm[0];
      s_tlast  = (frm.size() == 1);
      @(negedge clk);
      chk("lat_idle_tvalid", 32'(tvalid), 32'd0);
      @(posedge clk); #1;
      chk("lat_first_tvalid", 32'(tvalid), 32'd1);
      chk("lat_first_tdata", 32'(tdata), 32'h55);
      chk("lat_pre_tready", 32'(s_tready), 32'd0);
    end
    send_frame(-1, -1);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    wait_out(base + e.size());
    cmp_stream(tag, base, e);
    chk({tag, "_tready_cyc"}, 32'(tready_cnt - tr0), 32'(frm.size()));
    chk({tag, "_underrun"}, 32'(urun_cnt - ur0), 32'd0);
    chk_residue(tag, base + PRE_N + 1, base + e.size() - 1);
  endtask

  initial begin
    logic [7:0]  fa[$], fb[$], ea[$], eb[$], e[$];
    logic [31:0] w;
    int          base, tr0, ur0, ub0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tvalid", 32'(tvalid), 32'd0);
    chk("reset_tdata", 32'(tdata), 32'd0);
    chk("reset_tready", 32'(s_tready), 32'd0);
    chk("reset_underrun", 32'(underrun), 32'd0);
    rst = 1'b0;
    idle(3);

    // CRC unit on "123456789"
    c_init = 1'b1;
    @(posedge clk); #1;
    c_init = 1'b0;
    c_en   = 1'b1;
    for (int k = 0; k < 9; k++) begin
      c_data = 8'h31 + 8'(k);
      @(posedge clk); #1;
    end
    c_en = 1'b0;
    w = ~c_crc;
    chk("crc_check_value", w, 32'hCBF43926);
    chk("crc_wire_byte0", 32'(w[7:0]), 32'h26);
    chk("crc_wire_byte3", 32'(w[31:24]), 32'hCB);

    // exactly minimum length, counting pattern
    frm.delete();
    for (int k = 0; k < 60; k++) frm.push_back(8'(k));
    run_frame("f60", 1'b1);

    // padded frames and length boundaries
    fill_rand(14);  run_frame("f14", 1'b0);
    fill_rand(1);   run_frame("f1", 1'b1);
    fill_rand(59);  run_frame("f59", 1'b0);
    fill_rand(61);  run_frame("f61", 1'b0);

    // back-to-back 64-byte frames with s_tvalid never dropping
    fill_rand(64); fa = frm;
    fill_rand(64); fb = frm;
    build_exp(fa, ea);
    build_exp(fb, eb);
    e = {ea, eb};
    base = out_q.size();
    tr0  = tready_cnt;
    frm = fa; send_frame(-1, -1);
    frm = fb; send_frame(-1, -1);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    wait_out(base + e.size());
    cmp_stream("b2b", base, e);
    chk("b2b_ifg", 32'(gap_q[$]), 32'(IFG_N));
    chk("b2b_tready_cyc", 32'(tready_cnt - tr0), 32'd128);

    // underrun at byte 20 of a 100-byte frame
    fill_rand(100);
    e = {};
    repeat (PRE_N) e.push_back(8'h55);
    e.push_back(8'hD5);
    for (int k = 0; k < 20; k++) e.push_back(frm[k]);
    base = out_q.size();
    tr0  = tready_cnt;
    ur0  = urun_cnt;
    ub0  = urun_tv_bad;
    send_frame(20, -1);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    wait_out(base + e.size());
    cmp_stream("urun", base, e);
    chk("urun_pulses", 32'(urun_cnt - ur0), 32'd1);
    chk("urun_with_tvalid", 32'(urun_tv_bad - ub0), 32'd0);
    chk("urun_tready_cyc", 32'(tready_cnt - tr0), 32'd101);
    fill_rand(80); run_frame("after_urun", 1'b0);

    // reset during data byte 30
    fill_rand(100);
    send_frame(-1, 30);
    idle(5);
    chk("post_rst_tvalid", 32'(tvalid), 32'd0);
    fill_rand(70); run_frame("after_rst", 1'b1);

    // randomized frames with random idle time
    for (int n = 0; n < 6; n++) begin
      fill_rand(int'($urandom_range(1, 200)));
      run_frame($sformatf("rnd%0d", n), 1'b0);
      idle(int'($urandom_range(0, 15)));
    end

    // maximum-size frame: no pad
    fill_rand(1518);
    run_frame("f1518", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
